// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// Index helper supports up to 32 requesters.
package ring_arb_pkg;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_MAX_HOLD_DEF = 16;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Binary index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int onehot_to_idx(input logic [31:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module ring_rr_pick
  import ring_arb_pkg::*;
#(
  parameter int N = ARB_N_DEF
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] winner,
  output logic         any
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] dmask;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] lowest;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit search over everything at or above the pointer slot.
  assign dreq   = {req, req};
  assign dmask  = ~({ptr, ptr} - (2*N)'(1));
  assign masked = dreq & dmask;
  assign lowest = masked & (~masked + (2*N)'(1));

  assign winner = lowest[N-1:0] | lowest[2*N-1:N];
  assign any    = |req;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and hold limit.
// The owner-done input is named release_gnt because "release" is a reserved word.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int  N        = ARB_N_DEF,
  parameter int  MAX_HOLD = ARB_MAX_HOLD_DEF,
  localparam int ID_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            release_gnt,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic [N-1:0]    ptr,
  output logic            timeout
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t  state;
  logic [N-1:0] winner;
  logic         any;
  logic         owner_req;
  logic         hold_expired;
  logic         busy_exit;
  logic         timeout_only;
  logic [N-1:0] ptr_rot;

  ring_rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  assign owner_req    = |(req & gnt);
  assign busy_exit    = (state == ARB_BUSY) && (release_gnt || !owner_req || hold_expired);
  assign timeout_only = (state == ARB_BUSY) && hold_expired && !release_gnt && owner_req;
  assign ptr_rot      = (gnt << 1) | (gnt >> (N - 1));

  // The hold counter only exists when a limit is configured.
  generate
    if (MAX_HOLD == 0) begin : g_nohold
      assign hold_expired = 1'b0;
    end else begin : g_hold
      localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
      logic [HW-1:0] hold;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold <= '0;
        end else if (state == ARB_BUSY && !busy_exit) begin
          hold <= hold + HW'(1);
        end else begin
          hold <= '0;
        end
      end

      assign hold_expired = (hold == HOLD_LAST);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= N'(1);
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any) begin
            state     <= ARB_BUSY;
            gnt       <= winner;
            gnt_valid <= 1'b1;
            gnt_id    <= ID_W'(onehot_to_idx(32'(winner)));
          end
        end
        ARB_BUSY: begin
          // Every exit passes through idle so consecutive grants never abut.
          if (busy_exit) begin
            state     <= ARB_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= ptr_rot;
            timeout   <= timeout_only;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard bench for ring_rr_arbiter: directed scenarios then random traffic,
// checked against an index-based round-robin reference model.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int ID_W     = 2;

  typedef struct {
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic [N-1:0]    ptr;
    logic            timeout;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic            release_gnt;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic [N-1:0]    ptr;
  logic            timeout;

  exp_t expq[$];
  int   n_checks;
  int   n_fail;

  // Reference model: owner index (-1 when idle), priority index, cycles held.
  int m_owner;
  int m_prio;
  int m_held;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .release_gnt (release_gnt),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id),
    .ptr         (ptr),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    m_owner = -1;
    m_prio  = 0;
    m_held  = 0;
  endtask

  task automatic modelStep(input logic [N-1:0] r, input logic rel);
    exp_t e;
    bit   to;
    bit   found;
    to = 0;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_prio + k) % N;
        if (!found && r[idx]) begin
          found   = 1;
          m_owner = idx;
          m_held  = 1;
        end
      end
    end else begin
      bit gone;
      bit expired;
      gone    = rel || !r[m_owner];
      expired = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (gone || expired) begin
        to      = expired && !gone;
        m_prio  = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
    e.gnt       = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    e.gnt_valid = (m_owner >= 0);
    e.gnt_id    = (m_owner < 0) ? '0 : ID_W'(m_owner);
    e.ptr       = N'(1) << m_prio;
    e.timeout   = to;
    expq.push_back(e);
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then settle past the edge.
  task automatic applyStimulus(input logic [N-1:0] r, input logic rel);
    @(negedge clk);
    req         = r;
    release_gnt = rel;
    modelStep(r, rel);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every registered output once per edge against the model's prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("sb_gnt", 32'(gnt), 32'(e.gnt));
        checkOutput("sb_gnt_valid", 32'(gnt_valid), 32'(e.gnt_valid));
        checkOutput("sb_gnt_id", 32'(gnt_id), 32'(e.gnt_id));
        checkOutput("sb_ptr", 32'(ptr), 32'(e.ptr));
        checkOutput("sb_timeout", 32'(timeout), 32'(e.timeout));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] rreq;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    req         = '0;
    release_gnt = 1'b0;
    resetModel();

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_valid", 32'(gnt_valid), 32'h0);
    checkOutput("reset_id", 32'(gnt_id), 32'h0);
    checkOutput("reset_ptr", 32'(ptr), 32'h1);
    checkOutput("reset_timeout", 32'(timeout), 32'h0);

    // Single requester grant and release.
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_gnt", 32'(gnt), 32'h4);
    checkOutput("single_id", 32'(gnt_id), 32'd2);
    checkOutput("single_valid", 32'(gnt_valid), 32'h1);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_rel_gnt", 32'(gnt), 32'h0);
    checkOutput("single_rel_ptr", 32'(ptr), 32'h8);
    applyStimulus(4'b0000, 1'b0);

    // Asynchronous reset in the middle of a grant, between clock edges.
    applyStimulus(4'b0010, 1'b0);
    checkOutput("pre_async_gnt", 32'(gnt), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_gnt", 32'(gnt), 32'h0);
    checkOutput("async_rst_ptr", 32'(ptr), 32'h1);
    resetModel();
    req = '0;
    @(negedge clk);
    rst = 1'b0;

    // All requesting: grants rotate with a dead cycle between each.
    for (int i = 0; i < N; i++) begin
      applyStimulus(4'b1111, 1'b0);
      checkOutput("rot_gnt", 32'(gnt), 32'(1) << i);
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rot_idle", 32'(gnt), 32'h0);
      checkOutput("rot_ptr", 32'(ptr), 32'(1) << ((i + 1) % N));
    end
    applyStimulus(4'b1111, 1'b0);
    checkOutput("rot_wrap_gnt", 32'(gnt), 32'h1);
    applyStimulus(4'b0000, 1'b1);

    // Wrap-around search from the top slot.
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("wrap_ptr", 32'(ptr), 32'h8);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("wrap_gnt0", 32'(gnt), 32'h1);
    applyStimulus(4'b0011, 1'b1);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("wrap_gnt1", 32'(gnt), 32'h2);
    applyStimulus(4'b0000, 1'b0);

    // Hold limit revokes a grant after MAX_HOLD cycles.
    applyStimulus(4'b0010, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      applyStimulus(4'b0010, 1'b0);
      checkOutput("hold_gnt", 32'(gnt), 32'h2);
    end
    applyStimulus(4'b0010, 1'b0);
    checkOutput("hold_to_gnt", 32'(gnt), 32'h0);
    checkOutput("hold_to_pulse", 32'(timeout), 32'h1);
    checkOutput("hold_to_ptr", 32'(ptr), 32'h4);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("hold_regnt", 32'(gnt), 32'h2);
    checkOutput("hold_to_clear", 32'(timeout), 32'h0);
    applyStimulus(4'b0000, 1'b0);

    // Owner withdrawal, and release coinciding with the hold limit.
    applyStimulus(4'b0001, 1'b0);
    checkOutput("wd_gnt", 32'(gnt), 32'h1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("wd_idle", 32'(gnt), 32'h0);
    checkOutput("wd_timeout", 32'(timeout), 32'h0);
    checkOutput("wd_ptr", 32'(ptr), 32'h2);
    applyStimulus(4'b0001, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("rel_at_limit_gnt", 32'(gnt), 32'h0);
    checkOutput("rel_at_limit_timeout", 32'(timeout), 32'h0);

    // Random traffic with sticky requests so grants live long enough to hit the limit.
    rreq = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) rreq = N'($urandom_range(0, (1 << N) - 1));
      applyStimulus(rreq, ($urandom_range(0, 3) == 0));
    end

    applyStimulus(4'b0000, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("sb_drained", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
